fxp_mul_pipe: RTL
=================

// Module: fxp_mul_pipe
// PURPOSE
//  Signed fixed-point multiplier for the Mandelbrot iteration datapath (z*z, x*y, c terms).
//  Configurable pipeline depth, round-to-nearest, saturating output.
//  Valid/ready stream handshake with back-pressure; carries a per-operation tag (pixel/lane ID).
//  Replaces the go/done multiplier; successive operations issue back-to-back, one per cycle.
// PARAMETERS
//  WIDTH      64  total operand/result width, two's complement
//  INT_WIDTH  32  integer bits incl. sign; FRAC = WIDTH-INT_WIDTH (localparam)
//  STAGES     3   input-to-output latency in cycles; legal range >=3
//  ROUND      1   1: round half up at the FRAC boundary; 0: truncate toward -inf
//  SATURATE   1   1: clamp on overflow; 0: wrap (low WIDTH bits kept)
//  TAG_WIDTH  8   sideband tag width, passed through unchanged
// PORTS
//  clk        in   1          clock, rising edge
//  rst_n      in   1          asynchronous reset, active low
//  in_valid   in   1          operand pair valid
//  in_ready   out  1          block accepts operands this cycle
//  left       in   WIDTH      signed operand A
//  right      in   WIDTH      signed operand B
//  in_tag     in   TAG_WIDTH  sideband, returned with the result
//  out_valid  out  1          result valid
//  out_ready  in   1          consumer accepts the result
//  out        out  WIDTH      signed product, fixed-point format of the inputs
//  out_tag    out  TAG_WIDTH  tag of this result
//  ovf        out  1          result was saturated/wrapped; qualified by out_valid
// BEHAVIOUR
//  Reset: all valid bits, out, out_tag, ovf = 0. Internal data regs are also cleared, asynchronously.
//  advance = !out_valid || out_ready; in_ready = advance (combinational, no skid buffer).
//  Transfer in: in_valid && in_ready. Transfer out: out_valid && out_ready.
//  When advance=0 every stage holds: data, tag and valid stay frozen. No drops, no duplicates.
//  Order preserved. Throughput 1/cycle. Latency exactly STAGES cycles with no stall.
//  Stage 1 registers left/right/tag/valid.
//  Stage 2 registers the full 2*WIDTH signed product.
//  Stages 3..STAGES-1 are product delay registers; the final stage registers round+saturate.
//  Arithmetic (2*WIDTH+1 bits, signed):
//   p = left*right
//   r = p + (ROUND ? 1<<(FRAC-1) : 0)
//   q = r >>> FRAC
//  Overflow: q outside [-2^(WIDTH-1), 2^(WIDTH-1)-1].
//   SATURATE=1: out = {0,1..1} if q>0, {1,0..0} if q<0; ovf=1.
//   SATURATE=0: out = q[WIDTH-1:0]; ovf=1.
//  Note the min clamp is the most-negative value, not all-ones.
//  Bubbles (valid=0) propagate and may be collapsed only by normal advance; out holds the last value.
//  in_valid=1 with in_ready=0: inputs are ignored; the source must hold them.
//  Simultaneous in and out transfer with a full pipe is legal and sustains 1/cycle.
//  Reset mid-operation: all in-flight results are discarded; out_valid=0 on the cycle after rst_n falls.
// STRUCTURE
//  Package fxp_pkg: FXP_WIDTH/FXP_INT defaults.
//  Package fxp_pkg: fxp_t typedef (signed [WIDTH-1:0]).
//  Package fxp_pkg: function fxp_sat(signed wide, width) returning value+ovf.
//  Package fxp_pkg: constants FXP_ONE, FXP_MAX, FXP_MIN.
//  One sub-module: fxp_pipe_ctrl (per-stage valid shift chain + advance/in_ready logic).
//  The datapath stays inline.
// TESTING (W=64, I=32, STAGES=3, ROUND=1, SATURATE=1 unless noted)
//  1.0*1.0: 0x1_00000000 x2, out_ready=1 -> out=0x1_00000000, ovf=0.
//   out_valid exactly 3 cycles after accept.
//  -2.5*1.5 -> out=0xFFFFFFFC_40000000 (-3.75), ovf=0.
//  Max value times 2.0: left=0x7FFFFFFF_FFFFFFFF, right=0x2_00000000 -> out=0x7FFFFFFF_FFFFFFFF, ovf=1.
//   Same with left negated -> out=0x80000000_00000000, ovf=1.
//  Rounding: 0x80000000 (0.5) * 0x1 (2^-32) -> out=0x1 with ROUND=1, 0x0 with ROUND=0.
//   -0.5 * 2^-32 -> out=0x0 with ROUND=1.
//  Back-pressure: 6 back-to-back inputs tagged 0..5, out_ready low for cycles 4..8.
//   -> in_ready low while stalled; outputs tags 0..5 in order, each exactly once, values correct.
//  Reset mid-stream: assert rst_n=0 with 3 ops in flight.
//   -> out_valid=0 and out=0 immediately; after release, a new op returns after 3 cycles with its own tag.

Source files
------------

// File: rtl/fxp_pkg.sv
// Shared fixed-point types, constants and the saturate/wrap helper for the
// Mandelbrot datapath multipliers.
package fxp_pkg;

    localparam int FXP_WIDTH = 64;
    localparam int FXP_INT   = 32;
    localparam int FXP_FRAC  = FXP_WIDTH - FXP_INT;

    typedef logic signed [FXP_WIDTH-1:0] fxp_t;

    localparam fxp_t FXP_ONE = {{(FXP_INT-1){1'b0}}, 1'b1, {FXP_FRAC{1'b0}}};
    localparam fxp_t FXP_MAX = {1'b0, {(FXP_WIDTH-1){1'b1}}};
    localparam fxp_t FXP_MIN = {1'b1, {(FXP_WIDTH-1){1'b0}}};

    typedef struct packed {
        fxp_t val;
        logic ovf;
    } fxp_sat_t;

    // Narrows a wide signed value to 'width' bits. Callers with width < FXP_WIDTH
    // keep only the low 'width' bits of val; the clamp values are correct there.
    function automatic fxp_sat_t fxp_sat(input logic signed [2*FXP_WIDTH:0] v,
                                         input int width, input logic saturate);
        logic signed [2*FXP_WIDTH:0] one, mx, mn;
        fxp_sat_t res;
        one    = '0;
        one[0] = 1'b1;
        mx     = (one <<< (width - 1)) - one;
        mn     = -mx - one;
        res.ovf = (v > mx) || (v < mn);
        if (v > mx)
            res.val = saturate ? mx[FXP_WIDTH-1:0] : v[FXP_WIDTH-1:0];
        else if (v < mn)
            res.val = saturate ? mn[FXP_WIDTH-1:0] : v[FXP_WIDTH-1:0];
        else
            res.val = v[FXP_WIDTH-1:0];
        return res;
    endfunction

endpackage

// File: rtl/fxp_pipe_ctrl.sv
// Valid shift chain and stall control for the multiplier pipeline: every stage
// advances together unless the output holds a result the consumer refuses.
module fxp_pipe_ctrl #(
    parameter int STAGES = 3
) (
    input  logic clk,
    input  logic rst_n,
    input  logic in_valid,
    input  logic out_ready,
    output logic in_ready,
    output logic advance,
    output logic load_out,
    output logic out_valid
);

    logic [STAGES:1] vld_q, vld_d;

    always_comb begin
        advance = !vld_q[STAGES] || out_ready;
        vld_d   = vld_q;
        if (advance)
            vld_d = {vld_q[STAGES-1:1], in_valid};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            vld_q <= '0;
        else
            vld_q <= vld_d;
    end

    assign in_ready  = advance;
    // Bubbles leave the output register untouched so out keeps its last value.
    assign load_out  = advance && vld_q[STAGES-1];
    assign out_valid = vld_q[STAGES];

endmodule

// File: rtl/fxp_mul_pipe.sv
// Pipelined signed fixed-point multiplier with rounding, saturation and a
// valid/ready stream interface carrying a pass-through tag.
module fxp_mul_pipe
    import fxp_pkg::*;
#(
    parameter int WIDTH     = FXP_WIDTH,
    parameter int INT_WIDTH = FXP_INT,
    parameter int STAGES    = 3,
    parameter int ROUND     = 1,
    parameter int SATURATE  = 1,
    parameter int TAG_WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     left,
    input  logic [WIDTH-1:0]     right,
    input  logic [TAG_WIDTH-1:0] in_tag,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [WIDTH-1:0]     out,
    output logic [TAG_WIDTH-1:0] out_tag,
    output logic                 ovf
);

    localparam int FRAC = WIDTH - INT_WIDTH;
    localparam int DLY  = STAGES - 2;

    logic advance, load_out;

    fxp_pipe_ctrl #(.STAGES(STAGES)) u_ctrl (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .out_ready (out_ready),
        .in_ready  (in_ready),
        .advance   (advance),
        .load_out  (load_out),
        .out_valid (out_valid)
    );

    logic signed [WIDTH-1:0]         a_q, a_d, b_q, b_d;
    logic [DLY-1:0][2*WIDTH-1:0]     prod_q, prod_d;
    logic [STAGES-2:0][TAG_WIDTH-1:0] tag_q, tag_d;
    logic [WIDTH-1:0]                out_q, out_d;
    logic [TAG_WIDTH-1:0]            out_tag_q, out_tag_d;
    logic                            ovf_q, ovf_d;

    logic signed [2*WIDTH:0] rnd, rsum, q_w;
    fxp_sat_t                sat;

    always_comb begin
        a_d       = a_q;
        b_d       = b_q;
        prod_d    = prod_q;
        tag_d     = tag_q;
        out_d     = out_q;
        out_tag_d = out_tag_q;
        ovf_d     = ovf_q;

        // One guard bit above the product keeps the rounding add from wrapping.
        rnd = '0;
        if (ROUND != 0)
            rnd[FRAC-1] = 1'b1;
        rsum = (2*WIDTH+1)'($signed(prod_q[DLY-1])) + rnd;
        q_w  = rsum >>> FRAC;
        sat  = fxp_sat((2*FXP_WIDTH+1)'(q_w), WIDTH, SATURATE != 0);

        if (advance) begin
            a_d       = left;
            b_d       = right;
            tag_d[0]  = in_tag;
            prod_d[0] = (2*WIDTH)'(a_q) * (2*WIDTH)'(b_q);
            for (int i = 1; i < DLY; i++)
                prod_d[i] = prod_q[i-1];
            for (int i = 1; i < STAGES - 1; i++)
                tag_d[i] = tag_q[i-1];
        end

        if (load_out) begin
            out_d     = sat.val[WIDTH-1:0];
            out_tag_d = tag_q[STAGES-2];
            ovf_d     = sat.ovf;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q       <= '0;
            b_q       <= '0;
            prod_q    <= '0;
            tag_q     <= '0;
            out_q     <= '0;
            out_tag_q <= '0;
            ovf_q     <= 1'b0;
        end else begin
            a_q       <= a_d;
            b_q       <= b_d;
            prod_q    <= prod_d;
            tag_q     <= tag_d;
            out_q     <= out_d;
            out_tag_q <= out_tag_d;
            ovf_q     <= ovf_d;
        end
    end

    assign out     = out_q;
    assign out_tag = out_tag_q;
    assign ovf     = ovf_q;

endmodule
